// File: rtl/mem_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side not granted last.
module mem_rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (last_grant == GRANT_B) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU-data (A) and loader (B) access to a single-port synchronous-write RAM.
//
//   state | meaning
//   IDLE  | no transaction; RAM bus parked at zero
//   BUSY  | latched request driven onto the RAM bus; write commits on exit
//   ACK   | one-cycle ack to the winner; may accept the next request
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              win_q, win_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              busy_q, busy_d;
    logic [1:0]        grant;

    mem_rr_arb2 u_rr (
        .req        ({b_req, a_req}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        case (state_q)
            IDLE, ACK: begin
                if (grant != 2'b00) begin
                    state_d      = BUSY;
                    win_d        = grant[1] ? GRANT_B : GRANT_A;
                    last_grant_d = grant[1] ? GRANT_B : GRANT_A;
                    lat_we_d     = grant[1] ? b_we    : a_we;
                    lat_addr_d   = grant[1] ? b_addr  : a_addr;
                    lat_wdata_d  = grant[1] ? b_wdata : a_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                state_d = ACK;
                if (win_q == GRANT_B) begin
                    b_ack_d = 1'b1;
                    if (lat_we_q == READ) b_rdata_d = mem_rdata;
                end else begin
                    a_ack_d = 1'b1;
                    if (lat_we_q == READ) a_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == BUSY);
    end

    // Reset does not gate mem_rw: an in-flight write still lands at the reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_B;
            win_q        <= GRANT_A;
            lat_we_q     <= READ;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_rw    = READ;
        mem_wdata = '0;
        if (state_q == BUSY) begin
            mem_addr  = lat_addr_q;
            mem_rw    = lat_we_q;
            mem_wdata = lat_wdata_q;
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model plus a transaction-level reference with a shadow memory.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack, mem_rw, busy;
    logic [DW-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] ram    [0:65535];
    logic [DW-1:0] shadow [0:65535];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int rw_cnt = 0;
    int b_ack_cnt = 0;
    bit acks[$];

    // reference: a transaction is in flight for one cycle, then acked for one cycle
    bit          m_busy = 0, m_ack_a = 0, m_ack_b = 0, m_win = 0, m_last = 1, m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rd_a = '0, m_rd_b = '0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rw) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic poke(input logic [AW-1:0] addr, input logic [DW-1:0] val);
        ram[addr]    = val;
        shadow[addr] = val;
    endtask

    task automatic step();
        if (rst) begin
            if (m_busy && m_we) shadow[m_addr] = m_wdata;
            m_busy = 0; m_ack_a = 0; m_ack_b = 0; m_last = 1; m_win = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_rd_a = '0; m_rd_b = '0;
        end else if (m_busy) begin
            m_busy = 0;
            if (m_we) shadow[m_addr] = m_wdata;
            else if (m_win) m_rd_b = shadow[m_addr];
            else m_rd_a = shadow[m_addr];
            m_ack_a = !m_win;
            m_ack_b = m_win;
        end else begin
            m_ack_a = 0;
            m_ack_b = 0;
            if (a_req || b_req) begin
                m_win   = (a_req && b_req) ? !m_last : b_req;
                m_last  = m_win;
                m_we    = m_win ? b_we : a_we;
                m_addr  = m_win ? b_addr : a_addr;
                m_wdata = m_win ? b_wdata : a_wdata;
                m_busy  = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_rw) rw_cnt++;
        if (b_ack) b_ack_cnt++;
        if (a_ack) acks.push_back(1'b0);
        if (b_ack) acks.push_back(1'b1);
        chk("busy",      busy,      m_busy);
        chk("a_ack",     a_ack,     m_ack_a);
        chk("b_ack",     b_ack,     m_ack_b);
        chk("a_rdata",   a_rdata,   m_rd_a);
        chk("b_rdata",   b_rdata,   m_rd_b);
        chk("mem_rw",    mem_rw,    m_busy ? m_we : 1'b0);
        chk("mem_addr",  mem_addr,  m_busy ? m_addr : '0);
        chk("mem_wdata", mem_wdata, m_busy ? m_wdata : '0);
    endtask

    task automatic wait_ack(input bit port_b, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(port_b ? b_ack : a_ack) && n < budget);
        chk(port_b ? "ack_seen_b" : "ack_seen_a", port_b ? b_ack : a_ack, 1);
    endtask

    task automatic set_a(input bit req, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input bit req, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    initial begin
        int n;
        int ack_a_cyc;
        int b_before;
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = '0;
            shadow[i] = '0;
        end
        poke(16'h0000, 16'd42);
        poke(16'h0001, 16'd10);
        poke(16'h0020, 16'h5A5A);
        poke(16'h0021, 16'hA5A5);
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        rst = 1'b1;
        step();
        step();
        chk("reset_a_rdata", a_rdata, 16'h0000);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;

        // tie right after reset goes to A
        set_a(1, 0, 16'h0000, '0);
        set_b(1, 0, 16'h0001, '0);
        wait_ack(1'b0, 4, n);
        chk("tie_a_latency", n, 2);
        chk("tie_a_rdata", a_rdata, 16'd42);
        ack_a_cyc = cyc;
        a_req = 0;
        wait_ack(1'b1, 4, n);
        chk("tie_b_after_a", cyc - ack_a_cyc, 2);
        chk("tie_b_rdata", b_rdata, 16'd10);
        b_req = 0;

        // idle bus
        for (int i = 0; i < 10; i++) step();

        // A write then read back
        b_before = b_ack_cnt;
        set_a(1, 1, 16'h0002, 16'h1234);
        wait_ack(1'b0, 4, n);
        chk("wr_a_latency", n, 2);
        set_a(1, 0, 16'h0002, '0);
        wait_ack(1'b0, 4, n);
        chk("rd_a_latency", n, 2);
        chk("rd_a_rdata", a_rdata, 16'h1234);
        a_req = 0;
        step();
        chk("no_b_ack", b_ack_cnt - b_before, 0);

        // B write, single mem_rw pulse, A reads it back
        rw_cnt = 0;
        set_b(1, 1, 16'h0010, 16'hBEEF);
        wait_ack(1'b1, 4, n);
        b_req = 0;
        step();
        step();
        chk("b_wr_rw_pulses", rw_cnt, 1);
        set_a(1, 0, 16'h0010, '0);
        wait_ack(1'b0, 4, n);
        chk("rd_beef", a_rdata, 16'hBEEF);
        a_req = 0;
        step();

        // reset during BUSY of a B write: write lands, no ack
        b_before = b_ack_cnt;
        set_b(1, 1, 16'h0005, 16'h00AA);
        step();
        chk("b_wr_in_busy", busy, 1'b1);
        rst = 1'b1;
        b_req = 0;
        step();
        rst = 1'b0;
        step();
        step();
        chk("rst_no_b_ack", b_ack_cnt - b_before, 0);
        set_a(1, 0, 16'h0005, '0);
        wait_ack(1'b0, 4, n);
        chk("rd_after_rst", a_rdata, 16'h00AA);
        a_req = 0;

        // requester drops req mid-transaction; ack still comes
        set_b(1, 0, 16'h0021, '0);
        step();
        b_req = 0;
        step();
        chk("drop_still_ack", b_ack, 1'b1);
        chk("drop_rdata", b_rdata, 16'hA5A5);
        step();
        step();

        // continuous contention: strict alternation, last grant was B
        acks.delete();
        set_a(1, 0, 16'h0020, '0);
        set_b(1, 0, 16'h0021, '0);
        for (int i = 0; i < 16; i++) step();
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        chk("contend_ack_count", acks.size(), 8);
        for (int i = 0; i < 8 && i < acks.size(); i++)
            chk("contend_order", acks[i], (i % 2 == 1));
        step();
        step();

        // random traffic under the requester contract
        for (int i = 0; i < 400; i++) begin
            if (a_req && a_ack && $urandom_range(0, 1) == 0) a_req = 0;
            else if (a_ack || (!a_req && $urandom_range(0, 2) == 0))
                set_a(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            if (b_req && b_ack && $urandom_range(0, 1) == 0) b_req = 0;
            else if (b_ack || (!b_req && $urandom_range(0, 2) == 0))
                set_b(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, RAM address width; DATA_W, default 16, RAM word width.
REQ-002 Ports SHALL be as follows; the block SHALL use one clock, and reset SHALL be synchronous and active-high:
  clk  in  1  rising-edge clock, shared with RAM.
  rst  in  1  synchronous active-high reset.
  a_req / b_req  in  1  requester A (CPU data) / B (loader) transaction request.
  a_we / b_we  in  1  1 = write, 0 = read.
  a_addr / b_addr  in  ADDR_W  word address.
  a_wdata / b_wdata  in  DATA_W  write data.
  a_ack / b_ack  out  1  one-cycle completion pulse.
  a_rdata / b_rdata  out  DATA_W  registered read data, valid with ack, held until the next ack to that port.
  mem_addr  out  ADDR_W  RAM address.
  mem_rw  out  1  RAM rw (0 READ, 1 WRITE).
  mem_wdata  out  DATA_W  RAM write data.
  mem_rdata  in  DATA_W  RAM combinational read data.
  busy  out  1  high in BUSY.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY, ACK.
REQ-004 In IDLE or ACK with any req high, the block SHALL, at the next edge, latch the winner's we/addr/wdata, record the winner, and enter BUSY; with no req high, it SHALL enter (or stay in) IDLE.
REQ-005 Arbitration SHALL be round-robin: if only one req is high, that requester wins; if both are high, the requester not granted last wins; last_grant SHALL reset to B, so A wins the first tie.
REQ-006 In BUSY: mem_addr SHALL equal the latched addr, mem_wdata the latched wdata, and mem_rw the latched we; the RAM write SHALL commit on the edge leaving BUSY.
REQ-007 On the edge leaving BUSY: for a read, the block SHALL capture mem_rdata into the winner's rdata register; in all cases it SHALL enter ACK.
REQ-008 In ACK, the winner's ack SHALL be high for exactly one cycle; the other ack SHALL stay 0.
REQ-009 Outside BUSY, mem_rw SHALL be 0, mem_addr 0, and mem_wdata 0; the RAM SHALL NOT be written outside BUSY.
REQ-010 Requester contract:
  - hold req, we, addr and wdata stable from assertion until ack;
  - req still high in the ACK cycle SHALL be treated as a new request.
REQ-011 Latency and throughput:
  - latency from req sampled high in IDLE to ack SHALL be 2 cycles;
  - sustained throughput SHALL be one transaction per 2 cycles;
  - with both requesters continuously requesting, grants SHALL strictly alternate A, B, A, B.
REQ-012 A requester dropping req before ack (contract violation) SHALL NOT abort a transaction already in BUSY; the ack SHALL still be issued.
REQ-013 busy SHALL be high only in BUSY.

Reset
REQ-014 With rst high at an edge, the block SHALL set: state IDLE, last_grant B, latched fields 0, a_rdata/b_rdata 0, a_ack/b_ack 0.
REQ-015 After reset, mem_addr, mem_rw and mem_wdata SHALL be 0.
REQ-016 On reset asserted during BUSY: the RAM samples mem_rw=1 at that same edge, so an in-flight write SHALL commit; no ack SHALL be issued for it.
REQ-017 The RAM has no reset; memory contents SHALL survive rst.

Structure
REQ-018 Shared package mem_pkg SHALL hold:
  - the state enum (IDLE, BUSY, ACK);
  - READ=0 and WRITE=1 constants;
  - the default ADDR_W and DATA_W.
REQ-019 The two-way round-robin picker SHALL be a sub-module mem_rr_arb2 (inputs: req[1:0], last_grant; outputs: grant[1:0], one-hot or zero).
REQ-020 All outputs except mem_* SHALL be registered; mem_* SHALL be decoded combinationally from state and latched fields.

Verification
REQ-021 A write then read: a_req, a_we=1, a_addr=0x0002, a_wdata=0x1234; then a read of 0x0002 -> a_ack 2 cycles after each req; a_rdata=0x1234; b_ack never asserted.
REQ-022 Tie after reset: a_req and b_req rise together (A reads 0x0000 holding 42, B reads 0x0001 holding 10) -> A acked first with a_rdata=42; B acked 2 cycles later with b_rdata=10.
REQ-023 Continuous contention, both req held high for 8 transactions -> grant order A, B, A, B, A, B, A, B; one ack every 2 cycles; no missed or duplicate acks.
REQ-024 Write from B to 0x0010 of 0xBEEF -> mem_rw=1 for exactly one cycle; mem_rw=0 in all other cycles; a subsequent A read of 0x0010 returns 0xBEEF.
REQ-025 rst asserted during BUSY of a B write (0x0005, 0x00AA) -> state IDLE and no b_ack; a following A read of 0x0005 returns 0x00AA.
REQ-026 Idle bus, no req for 10 cycles -> mem_rw=0, mem_addr=0, busy=0 throughout.
